// File: rtl/aibcr3aux_osc_freqmon.sv
// Oscillator frequency monitor.
// The free-running 3-bit oscillator count is brought into the clk domain by a
// three-stage chain. A sample is used only when the last two stages agree, so
// a count caught mid-transition is never used. Modulo-8 deltas between used
// samples are accumulated over a fixed window of WIN_CYC clk cycles. At the end
// of the window the total and its threshold flags are published.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for meas_start; results hold their last values
// ARM   | waiting for a stable sample to use as the window reference
// MEAS  | counting window cycles and accumulating stable deltas
// DONE  | one cycle; registers osc_cnt/flags and pulses meas_done
module aibcr3aux_osc_freqmon #(
    parameter int WIN_CYC = 512,
    parameter int WIN_W   = 10,
    parameter int CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       bin_cnt,
    input  logic             meas_start,
    input  logic             meas_abort,
    input  logic             cont_mode,
    input  logic [CNT_W-1:0] thr_lo,
    input  logic [CNT_W-1:0] thr_hi,
    output logic             busy,
    output logic             meas_done,
    output logic [CNT_W-1:0] osc_cnt,
    output logic             freq_lo,
    output logic             freq_hi
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q,     state_d;
    logic [2:0]         s1_q,        s1_d;
    logic [2:0]         s2_q,        s2_d;
    logic [2:0]         s3_q,        s3_d;
    logic [2:0]         last_q,      last_d;
    logic [CNT_W-1:0]   acc_q,       acc_d;
    logic [WIN_W-1:0]   win_cnt_q,   win_cnt_d;
    logic               busy_q,      busy_d;
    logic               meas_done_q, meas_done_d;
    logic [CNT_W-1:0]   osc_cnt_q,   osc_cnt_d;
    logic               freq_lo_q,   freq_lo_d;
    logic               freq_hi_q,   freq_hi_d;

    logic               stable;
    logic [2:0]         delta;
    logic [CNT_W:0]     acc_sum;
    logic [CNT_W-1:0]   acc_sat;

    // Datapath helpers: stability test, modulo-8 delta and saturating sum.
    always_comb begin
        stable  = (s2_q == s3_q);
        delta   = s2_q - last_q;
        acc_sum = {1'b0, acc_q} + (CNT_W+1)'(delta);
        acc_sat = acc_sum[CNT_W] ? CNT_MAX : acc_sum[CNT_W-1:0];
    end

    // Next-state logic for the sync chain, FSM, window datapath and outputs.
    always_comb begin
        s1_d        = bin_cnt;
        s2_d        = s1_q;
        s3_d        = s2_q;
        state_d     = state_q;
        last_d      = last_q;
        acc_d       = acc_q;
        win_cnt_d   = win_cnt_q;
        meas_done_d = 1'b0;
        osc_cnt_d   = osc_cnt_q;
        freq_lo_d   = freq_lo_q;
        freq_hi_d   = freq_hi_q;

        case (state_q)
            ST_IDLE: begin
                if (meas_start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // The reference sample must be stable, otherwise the first
                // delta of the window could be taken from a torn count.
                if (stable) begin
                    last_d    = s2_q;
                    acc_d     = '0;
                    win_cnt_d = '0;
                    state_d   = ST_MEAS;
                end
            end
            ST_MEAS: begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                if (stable) begin
                    acc_d  = acc_sat;
                    last_d = s2_q;
                end
                if (win_cnt_q == WIN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                osc_cnt_d   = acc_q;
                freq_lo_d   = (acc_q < thr_lo);
                freq_hi_d   = (acc_q > thr_hi);
                meas_done_d = 1'b1;
                state_d     = cont_mode ? ST_ARM : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a result about to publish.
        if (meas_abort) begin
            state_d     = ST_IDLE;
            meas_done_d = 1'b0;
            osc_cnt_d   = osc_cnt_q;
            freq_lo_d   = freq_lo_q;
            freq_hi_d   = freq_hi_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            win_cnt_q   <= '0;
            busy_q      <= 1'b0;
            meas_done_q <= 1'b0;
            osc_cnt_q   <= '0;
            freq_lo_q   <= 1'b0;
            freq_hi_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            win_cnt_q   <= win_cnt_d;
            busy_q      <= busy_d;
            meas_done_q <= meas_done_d;
            osc_cnt_q   <= osc_cnt_d;
            freq_lo_q   <= freq_lo_d;
            freq_hi_q   <= freq_hi_d;
        end
    end

    assign busy      = busy_q;
    assign meas_done = meas_done_q;
    assign osc_cnt   = osc_cnt_q;
    assign freq_lo   = freq_lo_q;
    assign freq_hi   = freq_hi_q;

endmodule
